// File: rtl/pifo_dequeue_scheduler_if.sv
// rtl/pifo_dequeue_scheduler_if.sv - dequeue scheduler PIFO/Buffer Manager signal bundle
//
// Ports carried (named from the scheduler's point of view):
//   s_axis_pb_not_empty_array  PIFO block i holds at least one entry
//   s_axis_port_ready_array    egress port i can accept a packet
//   m_axis_to_pb_rd_en_array   one-hot single-cycle pop strobe to the PIFO blocks
//   s_axis_pb_head_valid       popped head entry valid
//   s_axis_pb_packet_addr      popped head packet address
//   s_axis_pb_meta_addr        popped head metadata address
//   m_axis_to_bm_rd_valid      read command valid to the Buffer Manager
//   s_axis_bm_rd_ready         Buffer Manager accepts the read command
//   m_axis_to_bm_packet_addr   latched packet address
//   m_axis_to_bm_meta_addr     latched metadata address
//   m_axis_to_bm_port          granted port index
//   s_axis_bm_rd_done          last beat of the packet has been sent
//   m_axis_busy                scheduler is not idle
//   m_axis_head_timeout        single-cycle pulse when a grant is abandoned
// Modports: master = scheduler side, slave = PIFO blocks / Buffer Manager side.
interface pifo_dequeue_scheduler_if #(
  parameter int PIFO_BLOCK_NUM      = 5,
  parameter int PACKET_BUFFER_WIDTH = 11,
  parameter int META_BUFFER_WIDTH   = 11
);
  localparam int PORT_WIDTH = (PIFO_BLOCK_NUM > 1) ? $clog2(PIFO_BLOCK_NUM) : 1;

  logic [PIFO_BLOCK_NUM-1:0]      s_axis_pb_not_empty_array;
  logic [PIFO_BLOCK_NUM-1:0]      s_axis_port_ready_array;
  logic [PIFO_BLOCK_NUM-1:0]      m_axis_to_pb_rd_en_array;
  logic                           s_axis_pb_head_valid;
  logic [PACKET_BUFFER_WIDTH-1:0] s_axis_pb_packet_addr;
  logic [META_BUFFER_WIDTH-1:0]   s_axis_pb_meta_addr;
  logic                           m_axis_to_bm_rd_valid;
  logic                           s_axis_bm_rd_ready;
  logic [PACKET_BUFFER_WIDTH-1:0] m_axis_to_bm_packet_addr;
  logic [META_BUFFER_WIDTH-1:0]   m_axis_to_bm_meta_addr;
  logic [PORT_WIDTH-1:0]          m_axis_to_bm_port;
  logic                           s_axis_bm_rd_done;
  logic                           m_axis_busy;
  logic                           m_axis_head_timeout;

  modport master (
    input  s_axis_pb_not_empty_array, s_axis_port_ready_array,
    input  s_axis_pb_head_valid, s_axis_pb_packet_addr, s_axis_pb_meta_addr,
    input  s_axis_bm_rd_ready, s_axis_bm_rd_done,
    output m_axis_to_pb_rd_en_array, m_axis_to_bm_rd_valid,
    output m_axis_to_bm_packet_addr, m_axis_to_bm_meta_addr, m_axis_to_bm_port,
    output m_axis_busy, m_axis_head_timeout
  );

  modport slave (
    output s_axis_pb_not_empty_array, s_axis_port_ready_array,
    output s_axis_pb_head_valid, s_axis_pb_packet_addr, s_axis_pb_meta_addr,
    output s_axis_bm_rd_ready, s_axis_bm_rd_done,
    input  m_axis_to_pb_rd_en_array, m_axis_to_bm_rd_valid,
    input  m_axis_to_bm_packet_addr, m_axis_to_bm_meta_addr, m_axis_to_bm_port,
    input  m_axis_busy, m_axis_head_timeout
  );
endinterface

// File: rtl/pifo_dequeue_scheduler.sv
// rtl/pifo_dequeue_scheduler.sv - PIFO dequeue scheduler, one packet outstanding
//
// Picks the next PIFO block to serve, pops its head entry, forwards the
// packet/metadata addresses to the Buffer Manager read port and waits for the
// packet to finish before granting again.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-low
//   bus    pifo_dequeue_scheduler_if.master (PIFO pop, head entry, BM read command,
//          busy and head-timeout status)
// Build option: PIFO_DEQ_STRICT_PRIO_EN selects lowest-index-first arbitration
// instead of round-robin.
module pifo_dequeue_scheduler #(
  parameter int PIFO_BLOCK_NUM      = 5,
  parameter int PACKET_BUFFER_WIDTH = 11,
  parameter int META_BUFFER_WIDTH   = 11,
  parameter int HEAD_TIMEOUT        = 16
) (
  input logic                      clk,
  input logic                      reset,
  pifo_dequeue_scheduler_if.master bus
);
  localparam int PORT_WIDTH = (PIFO_BLOCK_NUM > 1) ? $clog2(PIFO_BLOCK_NUM) : 1;

  typedef enum logic [2:0] {IDLE, POP, WAIT_HEAD, ISSUE, WAIT_DONE} state_t;

  state_t                         state_q, state_d;
  logic [PORT_WIDTH-1:0]          grant_ptr_q, grant_ptr_d;
  logic [7:0]                     timeout_cnt_q, timeout_cnt_d;
  logic [PIFO_BLOCK_NUM-1:0]      rd_en_q, rd_en_d;
  logic                           rd_valid_q, rd_valid_d;
  logic [PACKET_BUFFER_WIDTH-1:0] packet_addr_q, packet_addr_d;
  logic [META_BUFFER_WIDTH-1:0]   meta_addr_q, meta_addr_d;
  logic [PORT_WIDTH-1:0]          port_q, port_d;
  logic                           busy_q, busy_d;
  logic                           head_timeout_q, head_timeout_d;

  logic [PIFO_BLOCK_NUM-1:0]      eligible;
  logic [PORT_WIDTH-1:0]          winner;
  logic                           winner_found;

  assign eligible = bus.s_axis_pb_not_empty_array & bus.s_axis_port_ready_array;

`ifdef PIFO_DEQ_STRICT_PRIO_EN
  // Scan from the top down so the lowest eligible index is the last assignment.
  always_comb begin
    winner       = grant_ptr_q;
    winner_found = 1'b0;
    for (int i = PIFO_BLOCK_NUM - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner       = PORT_WIDTH'(i);
        winner_found = 1'b1;
      end
    end
  end
`else
  logic [PORT_WIDTH:0] scan_idx;

  // Candidates are grant_ptr+1 .. grant_ptr+N (mod N). Scanning the offsets in
  // descending order leaves the nearest eligible block after grant_ptr as the
  // winner; offset N revisits the last grant when it is the only eligible one.
  always_comb begin
    winner       = grant_ptr_q;
    winner_found = 1'b0;
    scan_idx     = '0;
    for (int i = PIFO_BLOCK_NUM; i >= 1; i--) begin
      scan_idx = {1'b0, grant_ptr_q} + (PORT_WIDTH + 1)'(i);
      if (scan_idx >= (PORT_WIDTH + 1)'(PIFO_BLOCK_NUM)) begin
        scan_idx = scan_idx - (PORT_WIDTH + 1)'(PIFO_BLOCK_NUM);
      end
      if (eligible[scan_idx[PORT_WIDTH-1:0]]) begin
        winner       = scan_idx[PORT_WIDTH-1:0];
        winner_found = 1'b1;
      end
    end
  end
`endif

  // Next-state and next-output logic; every output is registered from its _d value.
  always_comb begin
    state_d        = state_q;
    grant_ptr_d    = grant_ptr_q;
    timeout_cnt_d  = timeout_cnt_q;
    rd_en_d        = '0;
    rd_valid_d     = rd_valid_q;
    packet_addr_d  = packet_addr_q;
    meta_addr_d    = meta_addr_q;
    port_d         = port_q;
    head_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (winner_found) begin
          grant_ptr_d = winner;
          rd_en_d     = PIFO_BLOCK_NUM'(1) << winner;
          state_d     = POP;
        end
      end
      POP: begin
        timeout_cnt_d = '0;
        state_d       = WAIT_HEAD;
      end
      WAIT_HEAD: begin
        if (bus.s_axis_pb_head_valid) begin
          packet_addr_d = bus.s_axis_pb_packet_addr;
          meta_addr_d   = bus.s_axis_pb_meta_addr;
          port_d        = grant_ptr_q;
          rd_valid_d    = 1'b1;
          state_d       = ISSUE;
        end else if (timeout_cnt_q == 8'(HEAD_TIMEOUT - 1)) begin
          // grant_ptr keeps the abandoned block so the next scan starts after it.
          head_timeout_d = 1'b1;
          state_d        = IDLE;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
      end
      ISSUE: begin
        if (bus.s_axis_bm_rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.s_axis_bm_rd_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      grant_ptr_q    <= PORT_WIDTH'(PIFO_BLOCK_NUM - 1);
      timeout_cnt_q  <= '0;
      rd_en_q        <= '0;
      rd_valid_q     <= 1'b0;
      packet_addr_q  <= '0;
      meta_addr_q    <= '0;
      port_q         <= '0;
      busy_q         <= 1'b0;
      head_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_ptr_q    <= grant_ptr_d;
      timeout_cnt_q  <= timeout_cnt_d;
      rd_en_q        <= rd_en_d;
      rd_valid_q     <= rd_valid_d;
      packet_addr_q  <= packet_addr_d;
      meta_addr_q    <= meta_addr_d;
      port_q         <= port_d;
      busy_q         <= busy_d;
      head_timeout_q <= head_timeout_d;
    end
  end

  assign bus.m_axis_to_pb_rd_en_array = rd_en_q;
  assign bus.m_axis_to_bm_rd_valid    = rd_valid_q;
  assign bus.m_axis_to_bm_packet_addr = packet_addr_q;
  assign bus.m_axis_to_bm_meta_addr   = meta_addr_q;
  assign bus.m_axis_to_bm_port        = port_q;
  assign bus.m_axis_busy              = busy_q;
  assign bus.m_axis_head_timeout      = head_timeout_q;
endmodule

// File: tb/tb_pifo_dequeue_scheduler.sv
// tb/tb_pifo_dequeue_scheduler.sv - self-checking bench for pifo_dequeue_scheduler
module tb_pifo_dequeue_scheduler;
  logic clk;
  logic reset;

  pifo_dequeue_scheduler_if #(
    .PIFO_BLOCK_NUM(5), .PACKET_BUFFER_WIDTH(11), .META_BUFFER_WIDTH(11)
  ) bus ();

  pifo_dequeue_scheduler #(
    .PIFO_BLOCK_NUM(5), .PACKET_BUFFER_WIDTH(11), .META_BUFFER_WIDTH(11), .HEAD_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  not_empty;
    logic [4:0]  port_ready;
    logic [4:0]  exp_en;
    logic [2:0]  exp_port;
    logic [10:0] pkt;
    logic [10:0] meta;
    int          ready_delay;
  } vec_t;

  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completes one grant: waits for the pop strobe, returns the head one cycle
  // later, holds ready low for ready_delay ISSUE cycles, then sends rd_done.
  task automatic run_packet(input logic [4:0] exp_en, input logic [2:0] exp_port,
                            input logic [10:0] pkt, input logic [10:0] meta,
                            input int ready_delay);
    int n;
    n = 0;
    while (bus.m_axis_to_pb_rd_en_array == 5'b0 && n < 40) begin
      tick();
      n++;
    end
    check("pop_strobe", 64'(bus.m_axis_to_pb_rd_en_array), 64'(exp_en));
    tick();
    check("pop_one_cycle", 64'(bus.m_axis_to_pb_rd_en_array), 64'd0);
    bus.s_axis_pb_head_valid  = 1'b1;
    bus.s_axis_pb_packet_addr = pkt;
    bus.s_axis_pb_meta_addr   = meta;
    tick();
    bus.s_axis_pb_head_valid  = 1'b0;
    bus.s_axis_pb_packet_addr = 11'h7FF;
    bus.s_axis_pb_meta_addr   = 11'h7FF;
    check("issue_valid", 64'(bus.m_axis_to_bm_rd_valid), 64'd1);
    check("issue_port", 64'(bus.m_axis_to_bm_port), 64'(exp_port));
    check("issue_addrs", {42'd0, bus.m_axis_to_bm_packet_addr, bus.m_axis_to_bm_meta_addr},
          {42'd0, pkt, meta});
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      check("stall_hold", {41'd0, bus.m_axis_to_bm_rd_valid, bus.m_axis_to_bm_packet_addr,
                           bus.m_axis_to_bm_meta_addr}, {41'd0, 1'b1, pkt, meta});
    end
    bus.s_axis_bm_rd_ready = 1'b1;
    tick();
    bus.s_axis_bm_rd_ready = 1'b0;
    check("after_handshake", {62'd0, bus.m_axis_to_bm_rd_valid, bus.m_axis_busy}, 64'b01);
    repeat (3) tick();
    bus.s_axis_bm_rd_done = 1'b1;
    tick();
    bus.s_axis_bm_rd_done = 1'b0;
    check("done_idle", 64'(bus.m_axis_busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [4:0] to_first_en, to_next_en;
    logic [2:0] to_next_port;

`ifdef PIFO_DEQ_STRICT_PRIO_EN
    vecs[0] = '{5'b11111, 5'b11111, 5'b00001, 3'd0, 11'h101, 11'h011, 0};
    vecs[1] = '{5'b10110, 5'b11111, 5'b00010, 3'd1, 11'h102, 11'h012, 0};
    vecs[2] = '{5'b10110, 5'b11111, 5'b00010, 3'd1, 11'h103, 11'h014, 0};
    vecs[3] = '{5'b10110, 5'b11111, 5'b00010, 3'd1, 11'h104, 11'h015, 0};
    vecs[4] = '{5'b10110, 5'b11111, 5'b00010, 3'd1, 11'h105, 11'h016, 0};
    vecs[5] = '{5'b10110, 5'b11111, 5'b00010, 3'd1, 11'h2A5, 11'h013, 6};
    vecs[6] = '{5'b10101, 5'b11111, 5'b00001, 3'd0, 11'h106, 11'h017, 0};
    vecs[7] = '{5'b10101, 5'b11111, 5'b00001, 3'd0, 11'h107, 11'h018, 0};
    to_first_en  = 5'b01000;
    to_next_en   = 5'b01000;
    to_next_port = 3'd3;
`else
    vecs[0] = '{5'b11111, 5'b11111, 5'b00001, 3'd0, 11'h101, 11'h011, 0};
    vecs[1] = '{5'b10110, 5'b11111, 5'b00010, 3'd1, 11'h102, 11'h012, 0};
    vecs[2] = '{5'b10110, 5'b11111, 5'b00100, 3'd2, 11'h103, 11'h014, 0};
    vecs[3] = '{5'b10110, 5'b11111, 5'b10000, 3'd4, 11'h104, 11'h015, 0};
    vecs[4] = '{5'b10110, 5'b11111, 5'b00010, 3'd1, 11'h105, 11'h016, 0};
    vecs[5] = '{5'b10110, 5'b11111, 5'b00100, 3'd2, 11'h2A5, 11'h013, 6};
    vecs[6] = '{5'b10101, 5'b11111, 5'b10000, 3'd4, 11'h106, 11'h017, 0};
    vecs[7] = '{5'b10101, 5'b11111, 5'b00001, 3'd0, 11'h107, 11'h018, 0};
    to_first_en  = 5'b01000;
    to_next_en   = 5'b10000;
    to_next_port = 3'd4;
`endif

    reset = 1'b0;
    bus.s_axis_pb_not_empty_array = 5'b11111;
    bus.s_axis_port_ready_array   = 5'b11111;
    bus.s_axis_pb_head_valid      = 1'b0;
    bus.s_axis_pb_packet_addr     = '0;
    bus.s_axis_pb_meta_addr       = '0;
    bus.s_axis_bm_rd_ready        = 1'b0;
    bus.s_axis_bm_rd_done         = 1'b0;

    for (int c = 0; c < 3; c++) begin
      tick();
      check("reset_outputs", {31'd0, bus.m_axis_to_pb_rd_en_array, bus.m_axis_to_bm_rd_valid,
                              bus.m_axis_to_bm_packet_addr, bus.m_axis_to_bm_meta_addr,
                              bus.m_axis_to_bm_port, bus.m_axis_busy, bus.m_axis_head_timeout},
            64'd0);
    end
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      bus.s_axis_pb_not_empty_array = vecs[v].not_empty;
      bus.s_axis_port_ready_array   = vecs[v].port_ready;
      run_packet(vecs[v].exp_en, vecs[v].exp_port, vecs[v].pkt, vecs[v].meta,
                 vecs[v].ready_delay);
    end

    // Head timeout on block 3, then the follow-up grant.
    bus.s_axis_pb_not_empty_array = 5'b11000;
    bus.s_axis_port_ready_array   = 5'b11111;
    n = 0;
    while (bus.m_axis_to_pb_rd_en_array == 5'b0 && n < 40) begin
      tick();
      n++;
    end
    check("timeout_grant", 64'(bus.m_axis_to_pb_rd_en_array), 64'(to_first_en));
    tick();
    n = 0;
    while (bus.m_axis_head_timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("timeout_latency", 64'(n), 64'd16);
    check("timeout_idle", 64'(bus.m_axis_busy), 64'd0);
    tick();
    check("timeout_pulse_width", 64'(bus.m_axis_head_timeout), 64'd0);
    run_packet(to_next_en, to_next_port, 11'h108, 11'h019, 0);

    // Spurious head_valid/rd_done in IDLE, and block 0 gated by its port.
    bus.s_axis_pb_not_empty_array = 5'b00001;
    bus.s_axis_port_ready_array   = 5'b11110;
    tick();
    bus.s_axis_pb_head_valid = 1'b1;
    tick();
    bus.s_axis_pb_head_valid = 1'b0;
    bus.s_axis_bm_rd_done    = 1'b1;
    tick();
    bus.s_axis_bm_rd_done    = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("gated_idle", {57'd0, bus.m_axis_to_pb_rd_en_array, bus.m_axis_to_bm_rd_valid,
                           bus.m_axis_busy}, 64'd0);
    end
    bus.s_axis_port_ready_array = 5'b11111;
    run_packet(5'b00001, 3'd0, 11'h109, 11'h01A, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
